uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_pkg.sv | 22 ++
 rtl/tx_sync_fifo.sv | 53 +++++
 rtl/uart_tx_fifo.sv | 144 ++++++++++++++
 tb/tb_uart_tx_fifo.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmitter: FSM state encoding,
// parity mode codes and the bit-period divider calculation.
package uart_pkg;

  typedef enum logic [2:0] {
    TX_IDLE  = 3'd0,
    TX_START = 3'd1,
    TX_DATA  = 3'd2,
    TX_PAR   = 3'd3,
    TX_STOP  = 3'd4
  } tx_state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  // Clocks per line bit, truncated.
  function automatic int calc_div(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/tx_sync_fifo.sv
// Single-clock FIFO with show-ahead read port; pushes on a full FIFO and pops
// on an empty FIFO are ignored.
module tx_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      cnt;
  logic             do_push, do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointers are exactly AW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign full  = (cnt == (AW+1)'(DEPTH));
  assign empty = (cnt == '0);
  assign level = cnt;

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: start bit, DATA_BITS LSB first, optional parity,
// STOP_BITS stop bits. Parity is compiled in only with UART_TX_PARITY_EN defined.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY     = 0,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          CLK,
  input  logic                          RST_N,
  input  logic [DATA_BITS-1:0]          WR_DATA,
  input  logic                          WR_VALID,
  output logic                          WR_READY,
  output logic                          LINE_OUT,
  output logic                          BUSY,
  output logic [$clog2(FIFO_DEPTH):0]   LEVEL
);
  localparam int DIV = calc_div(CLK_FREQ, BAUD);
  localparam int CW  = $clog2(STOP_BITS * DIV);
  localparam int BW  = $clog2(DATA_BITS);

  localparam logic [CW-1:0] BIT_END  = CW'(DIV - 1);
  localparam logic [CW-1:0] STOP_END = CW'(STOP_BITS * DIV - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  localparam logic [2:0] ST_IDLE  = TX_IDLE;
  localparam logic [2:0] ST_START = TX_START;
  localparam logic [2:0] ST_DATA  = TX_DATA;
  localparam logic [2:0] ST_STOP  = TX_STOP;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] ST_PAR   = TX_PAR;
`endif

  logic [2:0]           state;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 line_out;
  logic                 cnt_end, pop;
  logic [DATA_BITS-1:0] fifo_dout;
  logic                 fifo_full, fifo_empty;

  tx_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .CLK(CLK), .RST_N(RST_N), .push(WR_VALID), .pop(pop), .din(WR_DATA),
    .dout(fifo_dout), .full(fifo_full), .empty(fifo_empty), .level(LEVEL)
  );

  assign cnt_end = (state == ST_STOP) ? (cnt == STOP_END) : (cnt == BIT_END);
  // Take the next entry when idle or as the last stop cycle ends (no gap).
  assign pop     = !fifo_empty && ((state == ST_IDLE) || ((state == ST_STOP) && cnt_end));

`ifdef UART_TX_PARITY_EN
  logic par_bit;
  always_ff @(posedge CLK) begin
    if (!RST_N)   par_bit <= 1'b0;
    else if (pop) par_bit <= (^fifo_dout) ^ (PARITY == PARITY_ODD);
  end
`else
  // Parity is not built in this configuration; PARITY has no effect.
  if (PARITY > PARITY_EVEN) begin : g_parity_ignored
  end
`endif

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state    <= ST_IDLE;
      line_out <= 1'b1;
      cnt      <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
    end else begin
      cnt <= cnt + 1'b1;
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (pop) begin
            state    <= ST_START;
            line_out <= 1'b0;
            shreg    <= fifo_dout;
          end
        end
        ST_START: if (cnt_end) begin
          cnt      <= '0;
          state    <= ST_DATA;
          line_out <= shreg[0];
          shreg    <= shreg >> 1;
          bit_idx  <= '0;
        end
        ST_DATA: if (cnt_end) begin
          cnt <= '0;
          if (bit_idx == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
            if (PARITY != PARITY_NONE) begin
              state    <= ST_PAR;
              line_out <= par_bit;
            end else begin
              state    <= ST_STOP;
              line_out <= 1'b1;
            end
`else
            state    <= ST_STOP;
            line_out <= 1'b1;
`endif
          end else begin
            line_out <= shreg[0];
            shreg    <= shreg >> 1;
            bit_idx  <= bit_idx + 1'b1;
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PAR: if (cnt_end) begin
          cnt      <= '0;
          state    <= ST_STOP;
          line_out <= 1'b1;
        end
`endif
        ST_STOP: if (cnt_end) begin
          cnt <= '0;
          if (pop) begin
            state    <= ST_START;
            line_out <= 1'b0;
            shreg    <= fifo_dout;
          end else begin
            state    <= ST_IDLE;
            line_out <= 1'b1;
          end
        end
        default: begin
          state    <= ST_IDLE;
          line_out <= 1'b1;
        end
      endcase
    end
  end

  assign LINE_OUT = line_out;
  assign BUSY     = (state != ST_IDLE);
  assign WR_READY = !fifo_full;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: three configurations (8N1/434, 7O1/4 depth 4, 8E2/434)
// checked against segment-level frame waveforms built from the frame rules.
module tb_uart_tx_fifo;
  localparam int DIV_A = 434;
  localparam int DIV_B = 4;
  localparam int DIV_C = 434;
  localparam int TR    = 50000;
`ifdef UART_TX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  typedef struct { logic v; int len; } seg_t;
  seg_t exp_q[$];

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  logic       a_rst_n, a_valid, a_ready, a_line, a_busy;
  logic [7:0] a_data;
  logic [4:0] a_level;
  logic       b_rst_n, b_valid, b_ready, b_line, b_busy;
  logic [6:0] b_data;
  logic [2:0] b_level;
  logic       c_rst_n, c_valid, c_ready, c_line, c_busy;
  logic [7:0] c_data;
  logic [4:0] c_level;

  uart_tx_fifo u_a (
    .CLK(CLK), .RST_N(a_rst_n), .WR_DATA(a_data), .WR_VALID(a_valid), .WR_READY(a_ready),
    .LINE_OUT(a_line), .BUSY(a_busy), .LEVEL(a_level));
  uart_tx_fifo #(.CLK_FREQ(400), .BAUD(100), .DATA_BITS(7), .STOP_BITS(1), .PARITY(1),
                 .FIFO_DEPTH(4)) u_b (
    .CLK(CLK), .RST_N(b_rst_n), .WR_DATA(b_data), .WR_VALID(b_valid), .WR_READY(b_ready),
    .LINE_OUT(b_line), .BUSY(b_busy), .LEVEL(b_level));
  uart_tx_fifo #(.DATA_BITS(8), .STOP_BITS(2), .PARITY(2)) u_c (
    .CLK(CLK), .RST_N(c_rst_n), .WR_DATA(c_data), .WR_VALID(c_valid), .WR_READY(c_ready),
    .LINE_OUT(c_line), .BUSY(c_busy), .LEVEL(c_level));

  // tr_*[k] holds the value present after the k-th rising edge.
  logic tr_line [3][TR];
  logic tr_busy [3][TR];
  always @(negedge CLK) if (cyc < TR) begin
    tr_line[0][cyc] <= a_line; tr_busy[0][cyc] <= a_busy;
    tr_line[1][cyc] <= b_line; tr_busy[1][cyc] <= b_busy;
    tr_line[2][cyc] <= c_line; tr_busy[2][cyc] <= c_busy;
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void add_frame(input int data, input int nbits, input int div,
                                    input int stops, input bit par, input bit odd);
    int ones = 0;
    exp_q.push_back('{1'b0, div});
    for (int i = 0; i < nbits; i++) begin
      exp_q.push_back('{1'((data >> i) & 1), div});
      ones += (data >> i) & 1;
    end
    if (par) exp_q.push_back('{1'((ones % 2) ^ int'(odd)), div});
    exp_q.push_back('{1'b1, stops * div});
  endfunction

  function automatic void add_idle(input int n);
    exp_q.push_back('{1'b1, n});
  endfunction

  function automatic int busy_run(input int sel, input int start);
    int n = 0;
    while (start + n < TR && tr_busy[sel][start + n] === 1'b1) n++;
    return n;
  endfunction

  // Compare the traced line against the queued segments, one check per segment.
  task automatic check_wave(input int sel, input int start, input string tag);
    int last = start;
    int c = start;
    int bad;
    foreach (exp_q[i]) last += exp_q[i].len;
    if (last + 2 >= TR) begin
      $display("FAIL %s: trace window exceeded (%0d)", tag, last);
      $fatal(1);
    end
    while (cyc <= last + 1) @(negedge CLK);
    foreach (exp_q[i]) begin
      bad = 0;
      for (int k = 0; k < exp_q[i].len; k++)
        if (tr_line[sel][c + k] !== exp_q[i].v) bad++;
      chk($sformatf("%s seg%0d bad_cycles", tag, i), bad, 0);
      c += exp_q[i].len;
    end
    exp_q.delete();
  endtask

  task automatic wr(input int sel, input logic [8:0] d, output int e);
    e = cyc + 1;
    case (sel)
      0:       begin a_data = d[7:0]; a_valid = 1'b1; end
      1:       begin b_data = d[6:0]; b_valid = 1'b1; end
      default: begin c_data = d[7:0]; c_valid = 1'b1; end
    endcase
    @(negedge CLK);
  endtask

  task automatic wr_end();
    a_valid = 1'b0; b_valid = 1'b0; c_valid = 1'b0;
  endtask

  initial begin
    #(TR * 10);
    $display("FAIL watchdog: cycle budget exhausted");
    $fatal(1);
  end

  initial begin
    int e, s, r, tmp, lvl, k;
    logic [8:0] d;
    logic [8:0] q[$];

    a_rst_n = 1'b0; b_rst_n = 1'b0; c_rst_n = 1'b0;
    a_valid = 1'b0; b_valid = 1'b0; c_valid = 1'b0;
    a_data = '0; b_data = '0; c_data = '0;
    repeat (3) @(negedge CLK);
    chk("rst line", a_line, 1);
    chk("rst busy", a_busy, 0);
    chk("rst level", a_level, 0);
    chk("rst ready", a_ready, 1);
    chk("rst b level", b_level, 0);
    chk("rst c ready", c_ready, 1);
    chk("rst c level", c_level, 0);
    a_rst_n = 1'b1; b_rst_n = 1'b1; c_rst_n = 1'b1;
    repeat (2) @(negedge CLK);

    // 8N1 single frame
    wr(0, 9'h55, e); wr_end(); s = e + 1;
    chk("8n1 line at write edge", a_line, 1);
    add_frame(8'h55, 8, DIV_A, 1, 1'b0, 1'b0); add_idle(10);
    check_wave(0, s, "8n1");
    chk("8n1 busy pre", tr_busy[0][s - 1], 0);
    chk("8n1 busy len", busy_run(0, s), 10 * DIV_A);

    // back-to-back burst
    wr(0, 9'h41, e); wr(0, 9'h42, tmp); wr(0, 9'h43, tmp); wr_end(); s = e + 1;
    add_frame(8'h41, 8, DIV_A, 1, 1'b0, 1'b0);
    add_frame(8'h42, 8, DIV_A, 1, 1'b0, 1'b0);
    add_frame(8'h43, 8, DIV_A, 1, 1'b0, 1'b0);
    add_idle(10);
    check_wave(0, s, "burst");
    chk("burst busy len", busy_run(0, s), 30 * DIV_A);

    // reset mid-DATA with a second entry queued
    wr(0, 9'h5A, e); wr(0, 9'h3C, tmp); wr_end(); s = e + 1;
    while (cyc < s + 3 * DIV_A) @(negedge CLK);
    chk("pre-reset level", a_level, 1);
    a_rst_n = 1'b0; r = cyc + 1;
    @(negedge CLK);
    chk("midrst line", a_line, 1);
    chk("midrst busy", a_busy, 0);
    chk("midrst level", a_level, 0);
    chk("midrst ready", a_ready, 1);
    a_rst_n = 1'b1;
    add_idle(s + 12 * DIV_A - r);
    check_wave(0, r, "post-reset idle");

    // 8E2 (parity only when compiled in)
    wr(2, 9'h07, e); wr_end(); s = e + 1;
    add_frame(8'h07, 8, DIV_C, 2, PAR_EN, 1'b0); add_idle(10);
    check_wave(2, s, "8e2");
    chk("8e2 busy len", busy_run(2, s), (PAR_EN ? 12 : 11) * DIV_C);

    // 7O1 0x7F
    wr(1, 9'h7F, e); wr_end(); s = e + 1;
    add_frame(7'h7F, 7, DIV_B, 1, PAR_EN, 1'b1); add_idle(DIV_B);
    check_wave(1, s, "7o1");

    // overfill a depth-4 FIFO while a frame is on the line
    d = 9'($urandom_range(0, 127));
    wr(1, d, e); wr_end(); s = e + 1;
    q.delete(); q.push_back(d);
    repeat (3) @(negedge CLK);
    lvl = 0;
    for (int i = 0; i < 6; i++) begin
      d = 9'($urandom_range(0, 127));
      chk($sformatf("depth ready%0d", i), b_ready, (lvl < 4) ? 1 : 0);
      wr(1, d, tmp);
      if (lvl < 4) begin lvl++; q.push_back(d); end
    end
    wr_end();
    chk("depth level", b_level, 4);
    chk("depth ready full", b_ready, 0);
    foreach (q[i]) add_frame(int'(q[i]), 7, DIV_B, 1, PAR_EN, 1'b1);
    add_idle(DIV_B);
    check_wave(1, s, "depth");

    // randomized short bursts into an idle transmitter
    for (int rnd = 0; rnd < 15; rnd++) begin
      k = $urandom_range(1, 4);
      q.delete();
      for (int i = 0; i < k; i++) begin
        d = 9'($urandom_range(0, 127));
        q.push_back(d);
        wr(1, d, tmp);
        if (i == 0) e = tmp;
      end
      wr_end();
      chk($sformatf("rnd%0d level", rnd), b_level, (k == 1) ? 1 : k - 1);
      s = e + 1;
      foreach (q[i]) add_frame(int'(q[i]), 7, DIV_B, 1, PAR_EN, 1'b1);
      add_idle(DIV_B);
      check_wave(1, s, $sformatf("rnd%0d", rnd));
      repeat ($urandom_range(0, 5)) @(negedge CLK);
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
